// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit.
// Holds the MDU operation encodings driven by the controller on `op`, the
// default multiply/divide latencies, and the width of the busy counter.
package mult_div_unit_pkg;

    // MDU operation encodings (3-bit `op` field); 6 and 7 are no-ops.
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // Default busy latencies in clock cycles.
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // Width of the busy down-counter.
    localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath of the multiply/divide unit.
// Ports:
//   op       in  3   latched MDU operation
//   a        in  32  latched rs operand (multiplicand / dividend)
//   b        in  32  latched rt operand (multiplier / divisor)
//   result   out 64  {HI, LO}: product, or {remainder, quotient}
//   div_zero out 1   divide operation with a zero divisor
module mdu_calc
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               is_div;
    logic               is_signed_div;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] mag_a;
    logic        [31:0] mag_b;
    logic        [31:0] safe_b;
    logic        [31:0] mag_q;
    logic        [31:0] mag_r;
    logic        [31:0] quot;
    logic        [31:0] rem;

    // Sign-extended and zero-extended 64-bit products.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign is_div        = (op == MDU_DIV) || (op == MDU_DIVU);
    assign is_signed_div = (op == MDU_DIV);
    assign div_zero      = is_div && (b == 32'd0);

    // Signed division is done on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 instead of relying on overflowing signed division.
    assign a_neg  = is_signed_div && a[31];
    assign b_neg  = is_signed_div && b[31];
    assign mag_a  = a_neg ? (~a + 32'd1) : a;
    assign mag_b  = b_neg ? (~b + 32'd1) : b;
    // A zero divisor is replaced so the divider never divides by zero; the
    // result is discarded by the caller via div_zero.
    assign safe_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign mag_q  = mag_a / safe_b;
    assign mag_r  = mag_a % safe_b;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quot = (a_neg ^ b_neg) ? (~mag_q + 32'd1) : mag_q;
    assign rem  = a_neg ? (~mag_r + 32'd1) : mag_r;

    always_comb begin
        result = 64'd0;
        case (op)
            MDU_MULT:           result = prod_s;
            MDU_MULTU:          result = prod_u;
            MDU_DIV, MDU_DIVU:  result = {rem, quot};
            default:            result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// A MULT/MULTU/DIV/DIVU accepted in IDLE latches its operands and keeps busy
// high for MULT_CYCLES or DIV_CYCLES; HI/LO take the result on the final busy
// edge. MTHI/MTLO write HI/LO directly in one cycle. Starts while busy and
// ops 6/7 are ignored.
// Ports:
//   clk     in  1   clock
//   reset   in  1   synchronous, active-high reset
//   start   in  1   MDU instruction valid in E stage this cycle
//   op      in  3   MDU operation (see mult_div_unit_pkg)
//   rs_val  in  32  forwarded GRF read data 1
//   rt_val  in  32  forwarded GRF read data 2
//   busy    out 1   calculation in progress (registered)
//   hi      out 32  HI register
//   lo      out 32  LO register
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_LOAD  = MDU_CNT_W'(DIV_CYCLES);

    logic [0:0]           state;
    logic [MDU_CNT_W-1:0] cnt;
    logic [2:0]           op_lat;
    logic [31:0]          a_lat;
    logic [31:0]          b_lat;
    logic [63:0]          result;
    logic                 div_zero;

    mdu_calc u_calc (
        .op       (op_lat),
        .a        (a_lat),
        .b        (b_lat),
        .result   (result),
        .div_zero (div_zero)
    );

    // busy is the state register itself, so it has no path from the inputs.
    assign busy = state[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_lat <= 3'd0;
            a_lat  <= 32'd0;
            b_lat  <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                op_lat <= op;
                                a_lat  <= rs_val;
                                b_lat  <= rt_val;
                                cnt    <= MULT_LOAD;
                                state  <= BUSY;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                op_lat <= op;
                                a_lat  <= rs_val;
                                b_lat  <= rt_val;
                                cnt    <= DIV_LOAD;
                                state  <= BUSY;
                            end
                            MDU_MTHI: hi <= rs_val;
                            MDU_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    // Last busy cycle: commit the result (unless the divisor
                    // was zero) and become idle for the next edge.
                    if (cnt == MDU_CNT_W'(1)) begin
                        state <= IDLE;
                        if (!div_zero) begin
                            hi <= result[63:32];
                            lo <= result[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
